// File: rtl/ibuf_pkg.sv
// Shared types and constants for the instruction-buffer writer and its buffer.
// The writer imports this package.
package ibuf_pkg;

    localparam int INSTR_W = 7;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 7'h00;
    localparam int IBUF_ENTRIES = 6;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2,
        TAIL  = 2'd3
    } ibuf_state_t;

endpackage

// File: rtl/ibuf_writer.sv
// Batch fill/drain sequencer for the shift-register instruction buffer. It writes
// one batch of ENTRIES slots, reads them all back, and forwards the real instructions.
module ibuf_writer
    import ibuf_pkg::*;
#(
    parameter int ENTRIES = IBUF_ENTRIES,
    parameter int CW      = $clog2(ENTRIES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               buf_wren,
    output logic               buf_rden,
    output logic [INSTR_W-1:0] buf_wdata,
    input  logic [INSTR_W-1:0] buf_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_last,
    output logic               busy
);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(ENTRIES - 1);

    ibuf_state_t   state;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] real_cnt;
    logic [CW-1:0] drain_idx;
    logic          handshake;

    // Upstream handshake: a transfer happens on a rising edge where in_valid and
    // in_ready are both high; upstream holds in_instr stable while in_ready is low.
    assign in_ready  = (state == FILL);
    assign busy      = (state != FILL);
    assign handshake = in_valid && in_ready;
    assign out_instr = buf_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            real_cnt  <= '0;
            drain_idx <= '0;
            buf_wren  <= 1'b0;
            buf_rden  <= 1'b0;
            buf_wdata <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            buf_wren  <= 1'b0;
            buf_rden  <= 1'b0;
            // Read data lags the strobe by one cycle, so qualify with the index of that read.
            out_valid <= buf_rden && (drain_idx < real_cnt);
            out_last  <= buf_rden && (drain_idx == (real_cnt - ONE));

            case (state)
                FILL: begin
                    if (handshake) begin
                        buf_wren  <= 1'b1;
                        buf_wdata <= in_instr;
                        fill_cnt  <= fill_cnt + ONE;
                        real_cnt  <= real_cnt + ONE;
                        if (fill_cnt == LAST_SLOT) begin
                            state <= DRAIN;
                        end else if (flush) begin
                            state <= PAD;
                        end
                    end else if (flush && (fill_cnt != '0)) begin
                        state <= PAD;
                    end
                end

                PAD: begin
                    buf_wren  <= 1'b1;
                    buf_wdata <= NOP_INSTR;
                    fill_cnt  <= fill_cnt + ONE;
                    if (fill_cnt == LAST_SLOT) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // The first DRAIN cycle still carries the last write, so reads start one cycle later.
                    if (!buf_rden) begin
                        buf_rden <= 1'b1;
                    end else if (drain_idx == LAST_SLOT) begin
                        state <= TAIL;
                    end else begin
                        buf_rden  <= 1'b1;
                        drain_idx <= drain_idx + ONE;
                    end
                end

                TAIL: begin
                    fill_cnt  <= '0;
                    real_cnt  <= '0;
                    drain_idx <= '0;
                    state     <= FILL;
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: doc/ibuf_writer.md
Name: ibuf_writer

Overview:
- Batch fill/drain sequencer that is the writing end of the ENTRIES-deep shift-register instruction buffer. It accepts 7-bit instructions over a valid/ready handshake and drives the buffer's write strobe and write data.
- Once a batch of exactly ENTRIES slots has been written, it drives the buffer's read strobe ENTRIES times and re-presents the returned instructions downstream in FIFO order.
- A flush input completes a partial batch by padding it with 7'h00 (NOP) writes. Padded slots are drained but never reported as valid.

Parameters:
- ENTRIES, 6, buffer depth; must match the buffer instance; must be >= 2.
- CW, 3, width of the count/index fields, $clog2(ENTRIES+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_instr  in  7  upstream instruction.
- in_ready  out  1  high when the block can accept an instruction.
- flush  in  1  complete the current partial batch now.
- buf_wren  out  1  buffer write strobe (registered).
- buf_rden  out  1  buffer read strobe (registered).
- buf_wdata  out  7  buffer write data (registered).
- buf_rdata  in  7  buffer read data; valid the cycle after buf_rden is sampled.
- out_valid  out  1  downstream instruction valid (registered).
- out_instr  out  7  downstream instruction; pass-through of buf_rdata.
- out_last  out  1  marks the last real instruction of a batch; qualified by out_valid.
- busy  out  1  high in any state other than FILL.

Behaviour:
- Reset values (async, active-low): state=FILL, fill_cnt=0, real_cnt=0, drain_idx=0, buf_wren=0, buf_rden=0, buf_wdata=0, out_valid=0, out_last=0.
- States and transitions:
  - FILL: in_ready=1, busy=0.
    - Handshake (in_valid & in_ready) at edge N: buf_wren=1 and buf_wdata=in_instr in cycle N+1; fill_cnt++ and real_cnt++.
    - Handshake with fill_cnt==ENTRIES-1: next state DRAIN.
    - flush with fill_cnt>0 and no handshake in the same cycle: next state PAD.
    - flush and handshake in the same cycle: accept the instruction first. Go to DRAIN if that filled the batch, otherwise PAD.
    - flush with fill_cnt==0: ignored.
  - PAD: in_ready=0.
    - Each cycle: buf_wren=1, buf_wdata=7'h00, fill_cnt++. real_cnt is unchanged.
    - When fill_cnt reaches ENTRIES: next state DRAIN.
  - DRAIN: in_ready=0.
    - buf_rden=1 for exactly ENTRIES consecutive cycles; drain_idx counts 0..ENTRIES-1.
    - The first buf_rden is asserted at least one cycle after the last buf_wren, so buf_wren and buf_rden are never high together.
    - After the last read: next state TAIL.
  - TAIL: wait one cycle for the final read data. Then clear fill_cnt, real_cnt and drain_idx, and go to FILL.
- Output timing:
  - out_valid is buf_rden delayed one cycle, gated by (delayed drain_idx < real_cnt).
  - out_instr = buf_rdata, driven combinationally.
  - out_last is high when the delayed drain_idx == real_cnt-1.
- Ordering: the first instruction accepted in a batch is the first out_valid beat. Padding slots are drained last and suppressed.
- No downstream backpressure: the consumer must accept one instruction per cycle.
- Latency: from the final fill handshake to the first out_valid is 3 cycles (wren, rden, data).
- in_valid asserted while in_ready=0 is held by upstream. No data is lost and no state changes.
- flush asserted in PAD, DRAIN or TAIL: ignored.
- Reset mid-batch: all counters and strobes clear immediately. Buffer contents are stale and harmless, because the next batch shifts ENTRIES new writes through before any read.
- Counters are CW bits wide and never wrap; every increment is bounded by ENTRIES.

Decomposition:
- Shared package ibuf_pkg:
  - INSTR_W=7
  - NOP_INSTR=7'h00
  - State enum {FILL, PAD, DRAIN, TAIL}
  - Default IBUF_ENTRIES=6
- Single module with no sub-module. The count/FSM logic is small.
- The integration top instantiates ibuf_writer next to the buffer, wiring buf_* to wren/rden/instr_in/instr_out.

Test Plan:
- Full batch: 6 back-to-back handshakes with 0x11..0x16 -> buf_wren high 6 cycles; then buf_rden high 6 cycles; out_valid 6 beats 0x11..0x16 in order; out_last on 0x16; busy falls after TAIL.
- Partial with flush: 0x21, 0x22 then flush -> 4 PAD writes of 0x00; 6 reads; out_valid only 2 beats (0x21, 0x22); out_last on 0x22.
- Flush and handshake same cycle: 5 writes, then the 6th write with flush -> no PAD cycles; straight to DRAIN with 6 valid beats.
- Backpressure upstream: hold in_valid with 0x3F during DRAIN -> in_ready=0 and no buf_wren. 0x3F is accepted on the first FILL cycle and becomes beat 1 of the next batch.
- Reset mid-DRAIN: pull rst_n low after 3 reads -> buf_rden/out_valid drop immediately, state FILL. A fresh 6-instruction batch 0x01..0x06 drains correctly.
- Idle flush: flush with fill_cnt=0 -> no buf_wren, busy stays 0.
